// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Conditions the raw board buttons into clean command pulses for the LED
// pattern FSM.
//
// Each channel is processed in three steps:
//   1. A two-flop synchronizer (s1, s2).
//   2. A stability counter. A level change is accepted only after DB_CYCLES
//      consecutive samples that differ from the current level.
//   3. Rising-edge detection.
// A priority filter then keeps only the highest-index request on any edge, so
// btn_pulse is always zero or one-hot.
//
// Optional feature (compile-time macro BTN_REPEAT_EN):
//   While a button stays held, it auto-repeats. The first repeat request comes
//   REPEAT_DELAY cycles after the press pulse. Further requests follow every
//   REPEAT_PERIOD cycles. Without the macro, no hold counters are built and
//   each accepted press gives exactly one pulse.
//
// Parameters:
//   N_BTN         number of button channels
//   DB_CYCLES     consecutive stable cycles needed to accept a change (>= 2)
//   REPEAT_DELAY  hold cycles from the press pulse to the first repeat
//   REPEAT_PERIOD cycles between auto-repeat pulses
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   btn_raw    raw, asynchronous, bouncing button pins
//   btn_level  debounced button levels (registered, not priority-filtered)
//   btn_pulse  one-cycle command pulse, zero or one-hot (registered)
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int N_BTN         = 4,
   parameter int DB_CYCLES     = 4,
   parameter int REPEAT_DELAY  = 16,
   parameter int REPEAT_PERIOD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse
);

   localparam int             CNT_W   = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic [N_BTN-1:0] s1;
   logic [N_BTN-1:0] s2;
   logic [CNT_W-1:0] cnt [N_BTN];

   logic [N_BTN-1:0] accept;
   logic [N_BTN-1:0] press_req;
   logic [N_BTN-1:0] req;
   logic [N_BTN-1:0] pulse_nxt;

   // A change is accepted on the edge where the counter has already seen
   // DB_CYCLES-1 differing samples and the current sample still differs.
   always_comb begin
      accept    = '0;
      press_req = '0;
      for (int i = 0; i < N_BTN; i++) begin
         accept[i]    = (s2[i] != btn_level[i]) && (cnt[i] == CNT_MAX);
         press_req[i] = accept[i] && s2[i];
      end
   end

   // ---- synchronizer and debounce stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1        <= '0;
         s2        <= '0;
         btn_level <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
         for (int i = 0; i < N_BTN; i++) begin
            if (s2[i] == btn_level[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               btn_level[i] <= s2[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef BTN_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
   localparam logic [HOLD_W-1:0] DLY_T = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PER_T = HOLD_W'(REPEAT_PERIOD - 1);

   logic [HOLD_W-1:0] hold [N_BTN];
   logic [N_BTN-1:0]  rep_phase;
   logic [N_BTN-1:0]  rep_req;

   // The hold counter is zero on the press edge, because the level was still
   // low before that edge. It then counts once per held cycle. A request
   // fires when it reaches the current target. The target is the delay for
   // the first repeat and the period for every repeat after that.
   always_comb begin
      rep_req = '0;
      for (int i = 0; i < N_BTN; i++) begin
         rep_req[i] = btn_level[i] && (hold[i] == (rep_phase[i] ? PER_T : DLY_T));
      end
   end

   // ---- hold counter stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_phase <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            hold[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (!btn_level[i]) begin
               hold[i]      <= '0;
               rep_phase[i] <= 1'b0;
            end else if (rep_req[i]) begin
               hold[i]      <= '0;
               rep_phase[i] <= 1'b1;
            end else begin
               hold[i] <= hold[i] + 1'b1;
            end
         end
      end
   end

   assign req = press_req | rep_req;
`else
   // The repeat parameters are accepted but have no effect in this build.
   if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_repeat_unused
   end

   assign req = press_req;
`endif

   // The loop runs from low to high index, so the highest requesting channel
   // wins. Lower requests on the same edge are dropped, not queued.
   always_comb begin
      pulse_nxt = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (req[i]) begin
            pulse_nxt    = '0;
            pulse_nxt[i] = 1'b1;
         end
      end
   end

   // ---- pulse output stage ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_pulse <= '0;
      end else begin
         btn_pulse <= pulse_nxt;
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed testbench for btn_debounce (DB_CYCLES = 4).
// Inputs change just after a falling edge. Outputs are sampled at falling
// edges. "k" is the number of rising edges since the input change, so a press
// pulse is expected at k = DB_CYCLES + 2 = 6.
module tb_btn_debounce;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_raw;
   logic [3:0] btn_level;
   logic [3:0] btn_pulse;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   btn_debounce #(
      .N_BTN(4),
      .DB_CYCLES(4),
      .REPEAT_DELAY(16),
      .REPEAT_PERIOD(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .btn_pulse(btn_pulse)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst     = 1'b1;
      btn_raw = 4'b0000;
      step(3);
      checks++;
      if (btn_level !== 4'b0000) begin
         errors++; $display("FAIL reset_level: got %b, expected %b", btn_level, 4'b0000);
      end
      checks++;
      if (btn_pulse !== 4'b0000) begin
         errors++; $display("FAIL reset_pulse: got %b, expected %b", btn_pulse, 4'b0000);
      end
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_clean_press;
      int first_k = -1;
      int pcount = 0;
      logic [3:0] first_val = '0;
      logic [3:0] lvl_k5 = '0;
      btn_raw = 4'b1000;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         if (btn_pulse !== 4'b0000) begin
            pcount++;
            if (first_k < 0) begin first_k = k; first_val = btn_pulse; end
         end
         if (k == 5) lvl_k5 = btn_level;
      end
      checks++;
      if (first_k !== 6) begin
         errors++; $display("FAIL clean_latency: got %0d, expected %0d", first_k, 6);
      end
      checks++;
      if (first_val !== 4'b1000) begin
         errors++; $display("FAIL clean_pulse_val: got %b, expected %b", first_val, 4'b1000);
      end
      checks++;
      if (pcount !== 1) begin
         errors++; $display("FAIL clean_pulse_count: got %0d, expected %0d", pcount, 1);
      end
      checks++;
      if (lvl_k5 !== 4'b0000) begin
         errors++; $display("FAIL clean_level_early: got %b, expected %b", lvl_k5, 4'b0000);
      end
      checks++;
      if (btn_level !== 4'b1000) begin
         errors++; $display("FAIL clean_level: got %b, expected %b", btn_level, 4'b1000);
      end
      btn_raw = 4'b0000;
      step(10);
   endtask

   task automatic test_bounce;
      int bounce_pulses = 0;
      int first_k = -1;
      int pcount = 0;
      logic [3:0] first_val = '0;
      for (int c = 0; c < 20; c++) begin
         btn_raw = ((c / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
         step(1);
         if (btn_pulse !== 4'b0000) bounce_pulses++;
      end
      btn_raw = 4'b0100;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         if (btn_pulse !== 4'b0000) begin
            pcount++;
            if (first_k < 0) begin first_k = k; first_val = btn_pulse; end
         end
      end
      checks++;
      if (bounce_pulses !== 0) begin
         errors++; $display("FAIL bounce_no_pulse: got %0d pulses, expected %0d", bounce_pulses, 0);
      end
      checks++;
      if (first_k !== 6) begin
         errors++; $display("FAIL bounce_latency: got %0d, expected %0d", first_k, 6);
      end
      checks++;
      if (first_val !== 4'b0100) begin
         errors++; $display("FAIL bounce_pulse_val: got %b, expected %b", first_val, 4'b0100);
      end
      checks++;
      if (pcount !== 1) begin
         errors++; $display("FAIL bounce_pulse_count: got %0d, expected %0d", pcount, 1);
      end
      btn_raw = 4'b0000;
      step(10);
   endtask

   task automatic test_release;
      int pcount = 0;
      logic [3:0] lvl_k5 = '0;
      btn_raw = 4'b0010;
      step(10);
      checks++;
      if (btn_level !== 4'b0010) begin
         errors++; $display("FAIL release_held_level: got %b, expected %b", btn_level, 4'b0010);
      end
      btn_raw = 4'b0000;
      for (int k = 1; k <= 10; k++) begin
         step(1);
         if (btn_pulse !== 4'b0000) pcount++;
         if (k == 5) lvl_k5 = btn_level;
      end
      checks++;
      if (lvl_k5 !== 4'b0010) begin
         errors++; $display("FAIL release_level_early: got %b, expected %b", lvl_k5, 4'b0010);
      end
      checks++;
      if (btn_level !== 4'b0000) begin
         errors++; $display("FAIL release_level: got %b, expected %b", btn_level, 4'b0000);
      end
      checks++;
      if (pcount !== 0) begin
         errors++; $display("FAIL release_no_pulse: got %0d pulses, expected %0d", pcount, 0);
      end
   endtask

   task automatic test_simultaneous;
      int pcount = 0;
      int low_seen = 0;
      int first_k = -1;
      logic [3:0] first_val = '0;
      btn_raw = 4'b1001;
      for (int k = 1; k <= 10; k++) begin
         step(1);
         if (btn_pulse !== 4'b0000) begin
            pcount++;
            if (btn_pulse[0]) low_seen++;
            if (first_k < 0) begin first_k = k; first_val = btn_pulse; end
         end
      end
      checks++;
      if (first_val !== 4'b1000 || first_k !== 6) begin
         errors++; $display("FAIL simul_pulse: got %b at k=%0d, expected %b at k=6", first_val, first_k, 4'b1000);
      end
      checks++;
      if (low_seen !== 0) begin
         errors++; $display("FAIL simul_low_dropped: got %0d low pulses, expected %0d", low_seen, 0);
      end
      checks++;
      if (pcount !== 1) begin
         errors++; $display("FAIL simul_pulse_count: got %0d, expected %0d", pcount, 1);
      end
      checks++;
      if (btn_level !== 4'b1001) begin
         errors++; $display("FAIL simul_level: got %b, expected %b", btn_level, 4'b1001);
      end
      btn_raw = 4'b0000;
      step(10);
   endtask

   task automatic test_async_reset;
      btn_raw = 4'b0100;
      step(8);
      checks++;
      if (btn_level !== 4'b0100) begin
         errors++; $display("FAIL async_pre_level: got %b, expected %b", btn_level, 4'b0100);
      end
      rst = 1'b1;
      #2;
      checks++;
      if (btn_level !== 4'b0000) begin
         errors++; $display("FAIL async_level_cleared: got %b, expected %b", btn_level, 4'b0000);
      end
      btn_raw = 4'b0000;
      step(2);
      rst = 1'b0;
      step(8);
      checks++;
      if (btn_level !== 4'b0000) begin
         errors++; $display("FAIL async_post_level: got %b, expected %b", btn_level, 4'b0000);
      end
   endtask

   task automatic test_reset_mid_count;
      int first_k = -1;
      int pcount = 0;
      int rst_bad = 0;
      logic [3:0] first_val = '0;
      btn_raw = 4'b0010;
      step(3);
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         if (btn_level !== 4'b0000 || btn_pulse !== 4'b0000) rst_bad++;
         step(1);
      end
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step(1);
         if (btn_pulse !== 4'b0000) begin
            pcount++;
            if (first_k < 0) begin first_k = k; first_val = btn_pulse; end
         end
      end
      checks++;
      if (rst_bad !== 0) begin
         errors++; $display("FAIL midreset_outputs_zero: got %0d nonzero samples, expected %0d", rst_bad, 0);
      end
      checks++;
      if (first_k !== 6) begin
         errors++; $display("FAIL midreset_latency: got %0d, expected %0d", first_k, 6);
      end
      checks++;
      if (first_val !== 4'b0010) begin
         errors++; $display("FAIL midreset_pulse_val: got %b, expected %b", first_val, 4'b0010);
      end
      checks++;
      if (pcount !== 1) begin
         errors++; $display("FAIL midreset_pulse_count: got %0d, expected %0d", pcount, 1);
      end
      btn_raw = 4'b0000;
      step(10);
   endtask

   task automatic test_auto_repeat;
      int times[$];
      int exp_t[$];
      int bad_val = 0;
`ifdef BTN_REPEAT_EN
      exp_t = '{6, 22, 30, 38, 46, 54};
`else
      exp_t = '{6};
`endif
      btn_raw = 4'b0001;
      for (int k = 1; k <= 64; k++) begin
         if (k == 51) btn_raw = 4'b0000;
         step(1);
         if (btn_pulse !== 4'b0000) begin
            times.push_back(k);
            if (btn_pulse !== 4'b0001) bad_val++;
         end
      end
      checks++;
      if (times.size() !== exp_t.size()) begin
         errors++; $display("FAIL repeat_count: got %0d, expected %0d", times.size(), exp_t.size());
      end
      checks++;
      if (bad_val !== 0) begin
         errors++; $display("FAIL repeat_pulse_val: got %0d wrong values, expected %0d", bad_val, 0);
      end
      for (int i = 0; i < exp_t.size(); i++) begin
         if (i < times.size()) begin
            checks++;
            if (times[i] !== exp_t[i]) begin
               errors++; $display("FAIL repeat_time_%0d: got %0d, expected %0d", i, times[i], exp_t[i]);
            end
         end
      end
      step(4);
   endtask

   initial begin
      rst     = 1'b1;
      btn_raw = 4'b0000;
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_simultaneous();
      test_async_reset();
      test_reset_mid_count();
      test_auto_repeat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Input-conditioning stage that sits directly upstream of the LED-pattern FSM. It turns the four raw, asynchronous, bouncing board buttons into clean single-cycle command pulses on `clk`, which the FSM consumes as its `btn` input. Each button is synchronized, debounced with a per-channel stability counter and edge-detected. A priority filter guarantees that at most one command pulse is issued per cycle.

## Interface
- `N_BTN`, 4: number of button channels.
- `DB_CYCLES`, 4: consecutive stable cycles required to accept a level change; must be ≥ 2. Small for simulation, large on the board.
- `REPEAT_DELAY`, 16: hold cycles after the press pulse before the first auto-repeat. Used only with `BTN_REPEAT_EN`.
- `REPEAT_PERIOD`, 8: cycles between auto-repeat pulses. Used only with `BTN_REPEAT_EN`.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `btn_raw`  in  N_BTN: raw button pins; asynchronous and bouncing.
- `btn_level`  out  N_BTN: debounced button level, registered.
- `btn_pulse`  out  N_BTN: one-hot-or-zero command pulse, registered; feeds the FSM `btn` input.

## Operation
- **Synchronizer:** per channel, two flops `s1 <= btn_raw`, `s2 <= s1`. Only `s2` is used downstream.
- **Debounce:** per channel, a counter `cnt` of width clog2(DB_CYCLES). On each edge:
  - if `s2 == btn_level[i]`: `cnt <= 0`;
  - else if `cnt == DB_CYCLES-1`: `btn_level[i] <= s2` and `cnt <= 0`;
  - else: `cnt <= cnt+1`.
- Any bounce back to the current level clears the count, so a change is accepted only after DB_CYCLES consecutive differing samples.
- **Edge detect:** a channel raises a request on the same edge its level updates 0→1. A 1→0 update raises no request.
- **Priority:** when several requests occur on one edge, only the highest-index channel drives `btn_pulse`. The other requests are dropped, not queued. This makes `btn_pulse` zero or one-hot.
- `btn_level` is not priority-filtered.
- **Reset:** `s1`, `s2`, `btn_level`, `cnt`, `btn_pulse` and the repeat counters all go to 0 immediately, including when reset arrives mid-count. A button still held when reset deasserts is treated as a new press.

## Timing
- Take `btn_raw` as changing and stable before edge 0:
  - `s1` updates at edge 0 and `s2` at edge 1;
  - `cnt` counts at edges 2…DB_CYCLES;
  - `btn_level` updates at edge DB_CYCLES+1.
- `btn_pulse` is high for exactly one cycle, starting at edge DB_CYCLES+1, simultaneously with the rise of `btn_level`.
- Press-to-pulse latency is DB_CYCLES+2 edges, counting edge 0. For the default that is 6.
- A release is accepted at the same latency and produces no pulse.
- A glitch lasting fewer than DB_CYCLES sampled cycles produces no change.
- `cnt` never exceeds DB_CYCLES-1, so there is no wrap-around.

## Configuration
- Macro: `BTN_REPEAT_EN`.
- **Defined:** each channel has a hold counter that starts at the press pulse and runs while `btn_level[i]` stays 1.
  - The first repeat request occurs REPEAT_DELAY cycles after the press pulse.
  - Further requests follow every REPEAT_PERIOD cycles.
  - Repeat requests pass through the same priority filter.
  - The counter clears when the level falls or on `rst`.
- **Undefined:** no hold counters are built. Exactly one pulse is produced per accepted press, regardless of hold time. The `REPEAT_*` parameters are ignored.

## Test plan
All scenarios use DB_CYCLES=4.
- **Clean press:** `rst` 1→0, then `btn_raw=4'b1000` held. Required: `btn_pulse=4'b1000` for one cycle starting 6 edges after the change, `btn_level=4'b1000` from then on, and `btn_pulse=0` afterwards.
- **Bounce:** `btn_raw[2]` toggles every 2 cycles for 20 cycles, then holds 1. Required: no pulse during the toggling, then a single `btn_pulse=4'b0100` 6 edges after the final rise.
- **Release:** from held `4'b0010`, set `btn_raw=0`. Required: `btn_level=0` 6 edges later and `btn_pulse` stays 0 throughout.
- **Simultaneous press:** `btn_raw` 0→`4'b1001` in the same cycle. Required: a single `btn_pulse=4'b1000`, no `4'b0001` pulse, and `btn_level=4'b1001`.
- **Reset mid-count:** press `btn_raw[1]`, assert `rst` 3 edges later, release `rst` after 2 cycles with the button still held. Required: all outputs 0 during reset, then `btn_pulse=4'b0010` 6 edges after `rst` falls.
- **Auto-repeat** (`BTN_REPEAT_EN` defined, REPEAT_DELAY=16, REPEAT_PERIOD=8): hold `btn_raw[0]` for 50 cycles. Required: pulses at press+0, +16, +24, +32, +40, +48. With the macro undefined: only the press+0 pulse.
